sift_rot_sample_seq: RTL

Sequences one 16x16 rotated descriptor-sampling pass per keypoint.
- Walks the 256 patch addresses through the per-direction rotated-offset ROM pair, which returns signed 5-bit dx/dy combinationally.
- Adds each offset to the keypoint coordinate, bounds-checks the result against the image, and streams sample coordinates to the window-memory reader under valid/ready.
- Sits between keypoint orientation assignment and descriptor histogram accumulation.

---
 rtl/sift_rot_sample_seq.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/sift_rot_sample_seq.sv
// -----------------------------------------------------------------------------
// sift_rot_sample_seq
//
// Sequences one 16x16 rotated descriptor-sampling pass per keypoint. The 256
// patch addresses are walked through the per-direction rotated-offset ROM pair
// (combinational signed 5-bit dx/dy). Each offset is added to the latched
// keypoint, clamped to the image, and streamed to the window-memory reader
// under a valid/ready handshake.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   start, abort           request a pass (only when idle) / cancel a pass
//   kp_x, kp_y, kp_dir     keypoint coordinate and orientation bin (latched)
//   rom_dir, rom_addr      ROM pair select and patch address {row, col}
//   rom_dx, rom_dy         signed offsets returned by the ROMs
//   busy                   pass in progress
//   out_valid, out_ready   sample stream handshake
//   out_x, out_y           clamped sample coordinate
//   out_idx, out_oob       patch address of sample / coordinate was clamped
//   out_last               sample is patch address 255
//   done                   one-cycle pulse at end of a completed pass
// -----------------------------------------------------------------------------
module sift_rot_sample_seq #(
    parameter int unsigned CW    = 10,
    parameter int unsigned IMG_W = 640,
    parameter int unsigned IMG_H = 480,
    parameter int unsigned DIRW  = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [CW-1:0]   kp_x,
    input  logic [CW-1:0]   kp_y,
    input  logic [DIRW-1:0] kp_dir,
    output logic [DIRW-1:0] rom_dir,
    output logic [7:0]      rom_addr,
    input  logic [4:0]      rom_dx,
    input  logic [4:0]      rom_dy,
    output logic            busy,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CW-1:0]   out_x,
    output logic [CW-1:0]   out_y,
    output logic [7:0]      out_idx,
    output logic            out_oob,
    output logic            out_last,
    output logic            done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [CW-1:0] XMAX = CW'(IMG_W - 1);
    localparam logic [CW-1:0] YMAX = CW'(IMG_H - 1);
    localparam logic [CW:0]   XLIM = (CW + 1)'(IMG_W);
    localparam logic [CW:0]   YLIM = (CW + 1)'(IMG_H);

    state_t          state_q;
    logic [CW-1:0]   kpx_q;
    logic [CW-1:0]   kpy_q;
    logic [DIRW-1:0] dir_q;
    logic [7:0]      cnt_q;
    logic            busy_q;
    logic            valid_q;
    logic [CW-1:0]   x_q;
    logic [CW-1:0]   y_q;
    logic [7:0]      idx_q;
    logic            oob_q;
    logic            last_q;
    logic            done_q;

    // Sums carry two bits above CW: the top bit is the sign, the next one keeps
    // a keypoint near 2^CW-1 plus a positive offset from looking negative.
    logic [CW+1:0]   sx;
    logic [CW+1:0]   sy;
    logic [CW-1:0]   x_d;
    logic [CW-1:0]   y_d;
    logic            oob_d;
    logic            adv;

    assign adv = !valid_q || out_ready;

    always_comb begin
        sx    = {2'b00, kpx_q} + {{(CW - 3){rom_dx[4]}}, rom_dx};
        sy    = {2'b00, kpy_q} + {{(CW - 3){rom_dy[4]}}, rom_dy};
        x_d   = sx[CW-1:0];
        y_d   = sy[CW-1:0];
        oob_d = 1'b0;
        if (sx[CW+1]) begin
            x_d   = '0;
            oob_d = 1'b1;
        end else if (sx[CW:0] >= XLIM) begin
            x_d   = XMAX;
            oob_d = 1'b1;
        end
        if (sy[CW+1]) begin
            y_d   = '0;
            oob_d = 1'b1;
        end else if (sy[CW:0] >= YLIM) begin
            y_d   = YMAX;
            oob_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            kpx_q   <= '0;
            kpy_q   <= '0;
            dir_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            idx_q   <= '0;
            oob_q   <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        kpx_q   <= kp_x;
                        kpy_q   <= kp_y;
                        dir_q   <= kp_dir;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (adv) begin
                        x_q     <= x_d;
                        y_q     <= y_d;
                        oob_q   <= oob_d;
                        idx_q   <= cnt_q;
                        last_q  <= (cnt_q == 8'hFF);
                        valid_q <= 1'b1;
                        // Counter parks at 255 so rom_addr never wraps into a
                        // second pass.
                        if (cnt_q == 8'hFF) begin
                            state_q <= S_DRAIN;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (abort) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (out_ready) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rom_dir   = dir_q;
    assign rom_addr  = cnt_q;
    assign busy      = busy_q;
    assign out_valid = valid_q;
    assign out_x     = x_q;
    assign out_y     = y_q;
    assign out_idx   = idx_q;
    assign out_oob   = oob_q;
    assign out_last  = last_q;
    assign done      = done_q;

endmodule
